lift_scan_controller: RTL and testbench

- Parametrised successor to the single-car five-floor lift FSM.
- Serves an N-floor shaft from a latched call bitmap using direction-preserving (SCAN/collective) scheduling.
- Models per-floor travel time and a door dwell timer.
- Returns the car to a configurable home floor after an idle timeout.
- Sits between the call-button/car-panel logic and the floor display / motor drive.

---
 rtl/lift_pkg.sv | 19 +
 rtl/lift_call_scan.sv | 28 ++
 rtl/lift_scan_controller.sv | 206 ++++++++++++++++++++
 tb/tb_lift_scan_controller.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared types for the lift scan controller: FSM states and direction encodings.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    function automatic logic [1:0] dir_code(input logic up);
        return up ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/lift_call_scan.sv
// Combinational scan of the call bitmap relative to a floor: calls above, below,
// at the floor, and ahead in the preferred direction.
module lift_call_scan #(
    parameter int N_FLOORS = 8,
    parameter int FLOOR_W  = 3
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                dir_pref,
    output logic                above,
    output logic                below,
    output logic                here,
    output logic                pref_ahead
);

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(current_floor))       above = above | pending[i];
            else if (i < int'(current_floor))  below = below | pending[i];
            else                               here  = pending[i];
        end
        pref_ahead = dir_pref ? above : below;
    end

endmodule

// File: rtl/lift_scan_controller.sv
// Single-car SCAN/collective lift controller for an N-floor shaft with travel and
// door timing and idle return to a home floor.
module lift_scan_controller
    import lift_pkg::*;
#(
    parameter int N_FLOORS     = 8,
    parameter int MOVE_CYCLES  = 4,
    parameter int DOOR_CYCLES  = 3,
    parameter int IDLE_TIMEOUT = 5,
    parameter int HOME_FLOOR   = 0,
    localparam int FLOOR_W     = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] call_req,
    output logic [N_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic [1:0]          direction,
    output logic                moving,
    output logic                door_open,
    output logic                arrived,
    output logic                homing
);

    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d, nf;
    logic [N_FLOORS-1:0]   pending_q, pending_d, latch_v, pend_nxt, call_mask;
    logic [1:0]            direction_q, direction_d;
    logic                  moving_q, moving_d, door_q, door_d, arrived_q, arrived_d;
    logic                  homing_q, homing_d, dir_pref_q, dir_pref_d;
    logic [MW-1:0]         move_cnt_q, move_cnt_d;
    logic [DW-1:0]         door_cnt_q, door_cnt_d;
    logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
    logic                  above, below, here, pref_ahead;
    logic                  above_n, below_n, here_n, pref_ahead_n;
    logic                  go_pref, any_call;

    // Scan at the current floor drives IDLE/DOOR decisions; scan at the next
    // floor (with this cycle's calls merged in) drives the arrival decision.
    lift_call_scan #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_cur (
        .pending(pending_q), .current_floor(floor_q), .dir_pref(dir_pref_q),
        .above(above), .below(below), .here(here), .pref_ahead(pref_ahead)
    );

    lift_call_scan #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_nxt (
        .pending(pend_nxt), .current_floor(nf), .dir_pref(dir_pref_q),
        .above(above_n), .below(below_n), .here(here_n), .pref_ahead(pref_ahead_n)
    );

    always_comb begin
        call_mask = '1;
        if (state_q == IDLE || state_q == DOOR) call_mask[floor_q] = 1'b0;
        latch_v  = call_req & call_mask;
        pend_nxt = pending_q | latch_v;
        nf       = (state_q == MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        pending_d   = pend_nxt;
        dir_pref_d  = dir_pref_q;
        homing_d    = homing_q;
        move_cnt_d  = move_cnt_q;
        door_cnt_d  = door_cnt_q;
        idle_cnt_d  = '0;
        arrived_d   = 1'b0;
        direction_d = DIR_NONE;
        go_pref     = 1'b0;
        any_call    = 1'b0;

        if (homing_q && (|latch_v)) homing_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (call_req[floor_q] || here) begin
                    pending_d[floor_q] = 1'b0;
                    state_d    = DOOR;
                    door_cnt_d = DW'(DOOR_CYCLES);
                end else if (above && (dir_pref_q || !below)) begin
                    state_d    = MOVE_UP;
                    dir_pref_d = 1'b1;
                    move_cnt_d = MW'(MOVE_CYCLES);
                end else if (below) begin
                    state_d    = MOVE_DOWN;
                    dir_pref_d = 1'b0;
                    move_cnt_d = MW'(MOVE_CYCLES);
                end else if (!(|call_req)) begin
                    idle_cnt_d = (idle_cnt_q == IW'(IDLE_TIMEOUT)) ? idle_cnt_q
                                                                  : idle_cnt_q + IW'(1);
                    if (idle_cnt_d == IW'(IDLE_TIMEOUT) && floor_q != FLOOR_W'(HOME_FLOOR)) begin
                        idle_cnt_d = '0;
                        homing_d   = 1'b1;
                        move_cnt_d = MW'(MOVE_CYCLES);
                        dir_pref_d = (floor_q < FLOOR_W'(HOME_FLOOR));
                        state_d    = (floor_q < FLOOR_W'(HOME_FLOOR)) ? MOVE_UP : MOVE_DOWN;
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (move_cnt_q == MW'(1)) begin
                    floor_d   = nf;
                    arrived_d = 1'b1;
                    if (here_n) begin
                        pending_d[nf] = 1'b0;
                        state_d       = DOOR;
                        door_cnt_d    = DW'(DOOR_CYCLES);
                        homing_d      = 1'b0;
                    end else if (pref_ahead_n || (homing_d && nf != FLOOR_W'(HOME_FLOOR))) begin
                        move_cnt_d = MW'(MOVE_CYCLES);
                    end else begin
                        state_d  = IDLE;
                        homing_d = 1'b0;
                    end
                end else begin
                    move_cnt_d = move_cnt_q - MW'(1);
                end
            end
            default: begin
                // DOOR: a fresh call at this floor keeps the door open a full dwell
                if (call_req[floor_q]) begin
                    door_cnt_d = DW'(DOOR_CYCLES);
                end else if (door_cnt_q == DW'(1)) begin
                    if (pref_ahead) begin
                        state_d    = dir_pref_q ? MOVE_UP : MOVE_DOWN;
                        move_cnt_d = MW'(MOVE_CYCLES);
                    end else if (above) begin
                        state_d    = MOVE_UP;
                        dir_pref_d = 1'b1;
                        move_cnt_d = MW'(MOVE_CYCLES);
                    end else if (below) begin
                        state_d    = MOVE_DOWN;
                        dir_pref_d = 1'b0;
                        move_cnt_d = MW'(MOVE_CYCLES);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    door_cnt_d = door_cnt_q - DW'(1);
                end
            end
        endcase

        // In DOOR the direction shows where the car will head next, if anywhere
        if (state_q == MOVE_UP || state_q == MOVE_DOWN) begin
            go_pref  = pref_ahead_n;
            any_call = above_n | below_n;
        end else begin
            go_pref  = pref_ahead;
            any_call = above | below;
        end
        case (state_d)
            MOVE_UP:   direction_d = DIR_UP;
            MOVE_DOWN: direction_d = DIR_DOWN;
            DOOR:      direction_d = go_pref  ? dir_code(dir_pref_d)  :
                                     any_call ? dir_code(!dir_pref_d) : DIR_NONE;
            default:   direction_d = DIR_NONE;
        endcase

        moving_d = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
        door_d   = (state_d == DOOR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            pending_q   <= '0;
            direction_q <= DIR_NONE;
            moving_q    <= 1'b0;
            door_q      <= 1'b0;
            arrived_q   <= 1'b0;
            homing_q    <= 1'b0;
            dir_pref_q  <= 1'b1;
            move_cnt_q  <= '0;
            door_cnt_q  <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            pending_q   <= pending_d;
            direction_q <= direction_d;
            moving_q    <= moving_d;
            door_q      <= door_d;
            arrived_q   <= arrived_d;
            homing_q    <= homing_d;
            dir_pref_q  <= dir_pref_d;
            move_cnt_q  <= move_cnt_d;
            door_cnt_q  <= door_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign pending       = pending_q;
    assign current_floor = floor_q;
    assign direction     = direction_q;
    assign moving        = moving_q;
    assign door_open     = door_q;
    assign arrived       = arrived_q;
    assign homing        = homing_q;

endmodule

// File: tb/tb_lift_scan_controller.sv
// Directed table-driven bench for lift_scan_controller at default parameters.
module tb_lift_scan_controller;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] call_req = '0;
    logic [7:0] pending;
    logic [2:0] current_floor;
    logic [1:0] direction;
    logic       moving, door_open, arrived, homing;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lift_scan_controller dut (
        .clk(clk), .rst_n(rst_n), .call_req(call_req), .pending(pending),
        .current_floor(current_floor), .direction(direction), .moving(moving),
        .door_open(door_open), .arrived(arrived), .homing(homing)
    );

    typedef struct {
        bit         rst;
        logic [7:0] call;
        int         cyc;
        logic [7:0] p;
        logic [2:0] f;
        logic [1:0] d;
        logic       m, o, a, h;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit rst, logic [7:0] call, int cyc, logic [7:0] p,
                                logic [2:0] f, logic [1:0] d, logic m, logic o,
                                logic a, logic h);
        vec_t v;
        v.rst = rst; v.call = call; v.cyc = cyc; v.p = p; v.f = f; v.d = d;
        v.m = m; v.o = o; v.a = a; v.h = h;
        vt.push_back(v);
    endfunction

    task automatic check(string name, logic [7:0] p, logic [2:0] f, logic [1:0] d,
                         logic m, logic o, logic a, logic h);
        n_total++;
        if ({pending, current_floor, direction, moving, door_open, arrived, homing} ===
            {p, f, d, m, o, a, h})
            n_pass++;
        else
            $display("FAIL %s: got p=%h f=%0d d=%b mv=%b door=%b arr=%b hom=%b, want p=%h f=%0d d=%b mv=%b door=%b arr=%b hom=%b",
                     name, pending, current_floor, direction, moving, door_open, arrived, homing,
                     p, f, d, m, o, a, h);
    endtask

    // Starts and ends on a falling edge; the call is presented for the first edge only.
    task automatic step(logic [7:0] c, int n);
        call_req = c;
        @(posedge clk);
        @(negedge clk);
        call_req = '0;
        for (int k = 1; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        call_req = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Call at 3 from floor 0
        add(1, 8'h08, 1,  8'h08, 0, 2'b00, 0, 0, 0, 0);
        add(0, 8'h00, 1,  8'h08, 0, 2'b01, 1, 0, 0, 0);
        add(0, 8'h00, 3,  8'h08, 0, 2'b01, 1, 0, 0, 0);
        add(0, 8'h00, 1,  8'h08, 1, 2'b01, 1, 0, 1, 0);
        add(0, 8'h00, 1,  8'h08, 1, 2'b01, 1, 0, 0, 0);
        add(0, 8'h00, 3,  8'h08, 2, 2'b01, 1, 0, 1, 0);
        add(0, 8'h00, 4,  8'h00, 3, 2'b00, 0, 1, 1, 0);
        add(0, 8'h00, 2,  8'h00, 3, 2'b00, 0, 1, 0, 0);
        add(0, 8'h00, 1,  8'h00, 3, 2'b00, 0, 0, 0, 0);
        // 0 -> 6 with an intermediate stop at 2 requested mid-travel
        add(1, 8'h40, 1,  8'h40, 0, 2'b00, 0, 0, 0, 0);
        add(0, 8'h00, 1,  8'h40, 0, 2'b01, 1, 0, 0, 0);
        add(0, 8'h04, 1,  8'h44, 0, 2'b01, 1, 0, 0, 0);
        add(0, 8'h00, 3,  8'h44, 1, 2'b01, 1, 0, 1, 0);
        add(0, 8'h00, 4,  8'h40, 2, 2'b01, 0, 1, 1, 0);
        add(0, 8'h00, 2,  8'h40, 2, 2'b01, 0, 1, 0, 0);
        add(0, 8'h00, 1,  8'h40, 2, 2'b01, 1, 0, 0, 0);
        add(0, 8'h00, 16, 8'h00, 6, 2'b00, 0, 1, 1, 0);
        add(0, 8'h00, 3,  8'h00, 6, 2'b00, 0, 0, 0, 0);
        // Call behind raised at floor 4 going up: serve 6, reverse, serve 1
        add(1, 8'h40, 1,  8'h40, 0, 2'b00, 0, 0, 0, 0);
        add(0, 8'h00, 17, 8'h40, 4, 2'b01, 1, 0, 1, 0);
        add(0, 8'h02, 1,  8'h42, 4, 2'b01, 1, 0, 0, 0);
        add(0, 8'h00, 7,  8'h02, 6, 2'b10, 0, 1, 1, 0);
        add(0, 8'h00, 3,  8'h02, 6, 2'b10, 1, 0, 0, 0);
        add(0, 8'h00, 4,  8'h02, 5, 2'b10, 1, 0, 1, 0);
        add(0, 8'h00, 16, 8'h00, 1, 2'b00, 0, 1, 1, 0);
        add(0, 8'h00, 3,  8'h00, 1, 2'b00, 0, 0, 0, 0);
        // Calls above and below together: last travel was down, so go down first
        add(0, 8'h09, 1,  8'h09, 1, 2'b00, 0, 0, 0, 0);
        add(0, 8'h00, 1,  8'h09, 1, 2'b10, 1, 0, 0, 0);
        add(0, 8'h00, 4,  8'h08, 0, 2'b01, 0, 1, 1, 0);
        // Idle at 5 then homing to 0 without opening the door
        add(1, 8'h20, 1,  8'h20, 0, 2'b00, 0, 0, 0, 0);
        add(0, 8'h00, 21, 8'h00, 5, 2'b00, 0, 1, 1, 0);
        add(0, 8'h00, 3,  8'h00, 5, 2'b00, 0, 0, 0, 0);
        add(0, 8'h00, 4,  8'h00, 5, 2'b00, 0, 0, 0, 0);
        add(0, 8'h00, 1,  8'h00, 5, 2'b10, 1, 0, 0, 1);
        add(0, 8'h00, 4,  8'h00, 4, 2'b10, 1, 0, 1, 1);
        add(0, 8'h00, 16, 8'h00, 0, 2'b00, 0, 0, 1, 0);
        // Door reload by a same-floor call on dwell cycle 2
        add(1, 8'h04, 1,  8'h04, 0, 2'b00, 0, 0, 0, 0);
        add(0, 8'h00, 9,  8'h00, 2, 2'b00, 0, 1, 1, 0);
        add(0, 8'h00, 1,  8'h00, 2, 2'b00, 0, 1, 0, 0);
        add(0, 8'h04, 1,  8'h00, 2, 2'b00, 0, 1, 0, 0);
        add(0, 8'h00, 2,  8'h00, 2, 2'b00, 0, 1, 0, 0);
        add(0, 8'h00, 1,  8'h00, 2, 2'b00, 0, 0, 0, 0);

        #1 rst_n = 1'b0;
        #2 check("reset_state", 8'h00, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            step(vt[i].call, vt[i].cyc);
            check($sformatf("vec%0d", i), vt[i].p, vt[i].f, vt[i].d,
                  vt[i].m, vt[i].o, vt[i].a, vt[i].h);
        end

        // Asynchronous reset while travelling between floors 3 and 4
        do_reset();
        step(8'h90, 1);
        check("pre_reset_latch", 8'h90, 0, 2'b00, 0, 0, 0, 0);
        step(8'h00, 14);
        check("pre_reset_travel", 8'h90, 3, 2'b01, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 8'h00, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h00, 10);
        check("post_reset_idle", 8'h00, 0, 2'b00, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
